// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch tick counter.
// Holds the run-control state encoding, BCD digit limits and the command decode.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  // clear has priority over start_stop from every state
  function automatic sw_state_t sw_next_state(input sw_state_t cur,
                                              input logic start_stop,
                                              input logic clear);
    sw_state_t nxt;
    nxt = cur;
    if (clear) begin
      nxt = IDLE;
    end else if (start_stop) begin
      case (cur)
        IDLE:    nxt = RUN;
        RUN:     nxt = PAUSE;
        PAUSE:   nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_tick_counter_bcd_digit.sv
// One BCD digit of the mm:ss cascade: counts 0..MAX on en, wraps to 0.
// carry is combinational so the next digit advances on the same edge.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = en & (q == MAX);

  // >= keeps the digit in range even if it were ever disturbed past MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= (q >= MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_tick_counter.sv
// mm:ss BCD stopwatch driven by rising edges of the 60 Hz divider output.
// Also pulses internal_reset so each fresh run starts on a new divider frame.
module stopwatch_tick_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_div,
  input  logic       start_stop,
  input  logic       clear,
  output logic       internal_reset,
  output logic       frame_tick,
  output logic       sec_tick,
  output logic       running,
  output logic       overflow,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens
);

  localparam int FW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(TICKS_PER_SEC - 1);

  sw_state_t     state;
  sw_state_t     state_nxt;
  logic          clk_div_q;
  logic          tick_evt;
  logic          count_en;
  logic          frame_wrap;
  logic          ir_nxt;
  logic [FW-1:0] frame_cnt;
  logic          so_carry;
  logic          st_carry;
  logic          mo_carry;
  logic          mt_carry;

  assign tick_evt   = clk_div & ~clk_div_q;
  assign count_en   = tick_evt & (state == RUN) & ~clear;
  assign frame_wrap = count_en & (frame_cnt == FRAME_LAST);
  assign running    = (state == RUN);

  // Resuming from PAUSE must not realign the divider, or the partial frame is lost
  always_comb begin
    state_nxt = sw_next_state(state, start_stop, clear);
    ir_nxt    = clear | ((state == IDLE) & start_stop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_div_q      <= 1'b0;
      state          <= IDLE;
      internal_reset <= 1'b0;
      frame_tick     <= 1'b0;
      sec_tick       <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      clk_div_q      <= clk_div;
      state          <= state_nxt;
      internal_reset <= ir_nxt;
      frame_tick     <= tick_evt;
      sec_tick       <= frame_wrap;
      overflow       <= mt_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (clear) begin
      frame_cnt <= '0;
    end else if (count_en) begin
      frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);
    end
  end

  bcd_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (frame_wrap),
    .q     (sec_ones),
    .carry (so_carry)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (so_carry),
    .q     (sec_tens),
    .carry (st_carry)
  );

  bcd_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (st_carry),
    .q     (min_ones),
    .carry (mo_carry)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_min_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (mo_carry),
    .q     (min_tens),
    .carry (mt_carry)
  );

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Self-checking bench: a tick-count reference model pushes expected frames and
// divider-reset pulses into queues; a negedge monitor pops and compares them.
module tb_stopwatch_tick_counter;

  localparam int TPS     = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk;
  logic       rst_n;
  logic       clk_div;
  logic       start_stop;
  logic       clear;
  logic       internal_reset;
  logic       frame_tick;
  logic       sec_tick;
  logic       running;
  logic       overflow;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;

  typedef struct {
    logic [15:0] digits;
    logic        sec_t;
    logic        ovf;
    logic        run;
  } frame_exp_t;

  frame_exp_t frame_q[$];
  int         ir_q[$];

  int compared   = 0;
  int mismatched = 0;
  int frame_seen = 0;
  int sec_seen   = 0;
  int ovf_seen   = 0;
  int ir_seen    = 0;
  int ir_pushed  = 0;

  int model_mode;
  int run_ticks;
  bit prev_div;

  stopwatch_tick_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_div        (clk_div),
    .start_stop     (start_stop),
    .clear          (clear),
    .internal_reset (internal_reset),
    .frame_tick     (frame_tick),
    .sec_tick       (sec_tick),
    .running        (running),
    .overflow       (overflow),
    .sec_ones       (sec_ones),
    .sec_tens       (sec_tens),
    .min_ones       (min_ones),
    .min_tens       (min_tens)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] model_digits(input int ticks);
    int secs;
    int mm;
    int ss;
    secs = (ticks / TPS) % 3600;
    mm   = secs / 60;
    ss   = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    model_mode = M_IDLE;
    run_ticks  = 0;
    prev_div   = 1'b0;
  endtask

  // Drive one cycle of inputs and record what the stopwatch must do with them
  task automatic apply_stimulus(input bit div, input bit ss, input bit clr);
    bit         tick;
    frame_exp_t e;
    @(posedge clk);
    #1;
    clk_div    = div;
    start_stop = ss;
    clear      = clr;
    tick       = div && !prev_div;
    prev_div   = div;
    e.sec_t    = 1'b0;
    e.ovf      = 1'b0;
    if (clr) begin
      model_mode = M_IDLE;
      run_ticks  = 0;
      ir_q.push_back(1);
      ir_pushed++;
    end else begin
      if (tick && model_mode == M_RUN) begin
        run_ticks++;
        e.sec_t = ((run_ticks % TPS) == 0);
        e.ovf   = ((run_ticks % (TPS * 3600)) == 0);
      end
      if (ss) begin
        if (model_mode == M_IDLE) begin
          model_mode = M_RUN;
          ir_q.push_back(1);
          ir_pushed++;
        end else if (model_mode == M_RUN) begin
          model_mode = M_PAUSE;
        end else begin
          model_mode = M_RUN;
        end
      end
    end
    if (tick) begin
      e.digits = model_digits(run_ticks);
      e.run    = (model_mode == M_RUN);
      frame_q.push_back(e);
    end
  endtask

  task automatic run_period(input int hi, input int lo, input bit ss_on_rise);
    apply_stimulus(1'b1, ss_on_rise, 1'b0);
    for (int i = 1; i < hi; i++) apply_stimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < lo; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_frame_tick"}, frame_tick, 0);
    check_output({tag, "_sec_tick"}, sec_tick, 0);
    check_output({tag, "_overflow"}, overflow, 0);
    check_output({tag, "_running"}, running, 0);
    check_output({tag, "_internal_reset"}, internal_reset, 0);
    check_output({tag, "_digits"}, dut_digits(), 0);
  endtask

  // Monitor: every frame_tick must match the next expected frame, nothing else may pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_tick) begin
        frame_seen++;
        check_output("frame_expected", 32'(frame_q.size() > 0), 1);
        if (frame_q.size() > 0) begin
          frame_exp_t e;
          e = frame_q.pop_front();
          check_output("frame_digits", dut_digits(), e.digits);
          check_output("frame_sec_tick", sec_tick, e.sec_t);
          check_output("frame_overflow", overflow, e.ovf);
          check_output("frame_running", running, e.run);
        end
      end else begin
        check_output("stray_sec_or_overflow", {sec_tick, overflow}, 0);
      end
      if (sec_tick) sec_seen++;
      if (overflow) ovf_seen++;
      if (internal_reset) begin
        ir_seen++;
        check_output("internal_reset_expected", 32'(ir_q.size() > 0), 1);
        if (ir_q.size() > 0) void'(ir_q.pop_front());
      end
    end
  end

  initial begin
    int f0;
    int s0;
    int o0;
    rst_n      = 1'b0;
    clk_div    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    model_reset();
    #23;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] idle ticks");
    f0 = frame_seen;
    for (int i = 0; i < 20; i++) run_period(5, 5, 1'b0);
    drain();
    check_output("idle_frame_count", frame_seen - f0, 20);
    check_output("idle_digits", dut_digits(), 16'h0000);
    check_output("idle_running", running, 0);

    $display("[TB] start and count");
    s0 = sec_seen;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("start_internal_reset", internal_reset, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("start_internal_reset_width", internal_reset, 0);
    for (int i = 0; i < 8; i++) run_period(5, 5, 1'b0);
    drain();
    check_output("run8_digits", dut_digits(), 16'h0002);
    check_output("run8_sec_ticks", sec_seen - s0, 2);
    check_output("run8_running", running, 1);

    $display("[TB] pause and resume on tick edges");
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    s0 = sec_seen;
    for (int i = 0; i < 5; i++) run_period(5, 5, 1'b0);
    run_period(5, 5, 1'b1);
    for (int i = 0; i < 10; i++) run_period(5, 5, 1'b0);
    check_output("paused_running", running, 0);
    run_period(5, 5, 1'b1);
    for (int i = 0; i < 2; i++) run_period(5, 5, 1'b0);
    drain();
    check_output("resume_digits", dut_digits(), 16'h0002);
    check_output("resume_sec_ticks", sec_seen - s0, 2);

    $display("[TB] preload to 59:59 and wrap");
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TPS * 3600 - 1; i++) run_period(1, 1, 1'b0);
    drain();
    check_output("preload_digits", dut_digits(), 16'h5959);
    o0 = ovf_seen;
    run_period(5, 5, 1'b0);
    drain();
    check_output("wrap_digits", dut_digits(), 16'h0000);
    check_output("wrap_overflow_count", ovf_seen - o0, 1);
    check_output("wrap_running", running, 1);

    $display("[TB] clear and start_stop together");
    for (int i = 0; i < 3; i++) run_period(5, 5, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    drain();
    check_output("clear_wins_running", running, 0);
    check_output("clear_wins_digits", dut_digits(), 16'h0000);

    $display("[TB] async reset at 00:37");
    apply_stimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 37 * TPS; i++) run_period(5, 5, 1'b0);
    drain();
    check_output("pre_reset_digits", dut_digits(), 16'h0037);
    check_output("pre_reset_queue_empty", frame_q.size(), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) run_period(5, 5, 1'b0);
    drain();
    check_output("post_reset_running", running, 0);
    check_output("post_reset_digits", dut_digits(), 16'h0000);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
                     ($urandom_range(0, 59) == 0));
    end
    drain();
    check_output("end_frames_pending", frame_q.size(), 0);
    check_output("end_internal_reset_pending", ir_q.size(), 0);
    check_output("end_internal_reset_total", ir_seen, ir_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
